instr_mem_loader: RTL and testbench

Boot-time writer for a core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word goes into the instruction RAM through a single write port, using the byte addressing the fetch side uses (word index = address >> 2). The attached core is held off until the requested number of words has been written.

---
 rtl/instr_mem_loader_if.sv | 28 ++
 rtl/instr_mem_loader.sv | 120 ++++++++++++
 tb/tb_instr_mem_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte stream in, instruction RAM write port out
// The loader uses the master modport; the stream source / RAM side uses slave.
interface instr_mem_loader_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (
      input  byte_in,
      input  byte_valid,
      output byte_ready,
      output wr_en,
      output wr_addr,
      output wr_data
   );

   modport slave (
      output byte_in,
      output byte_valid,
      input  byte_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data
   );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot loader assembling LE bytes into instruction words
// Holds the core until len_words words have been written at byte addresses word<<2.
module instr_mem_loader #(
   parameter int DEPTH = 128
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [7:0]           len_words,
   instr_mem_loader_if.master   bus,
   output logic                 core_hold,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   state_t      state_q;
   logic [1:0]  byte_cnt_q;
   logic [7:0]  word_cnt_q;
   logic [7:0]  len_q;
   logic [31:0] asm_q;
   logic [31:0] asm_d;
   logic        byte_ready_q;
   logic        wr_en_q;
   logic [31:0] wr_addr_q;
   logic [31:0] wr_data_q;
   logic        core_hold_q;
   logic        done_q;
   logic        err_q;
   logic        accept;
   logic        last_word;

   // byte_ready_q is only ever high in RECV, so it doubles as the state qualifier
   assign accept    = bus.byte_valid && byte_ready_q;
   assign last_word = (word_cnt_q == len_q - 8'd1);

   always_comb begin
      asm_d = asm_q;
      asm_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         byte_cnt_q   <= 2'd0;
         word_cnt_q   <= 8'd0;
         len_q        <= 8'd0;
         asm_q        <= 32'd0;
         byte_ready_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= 32'd0;
         wr_data_q    <= 32'd0;
         core_hold_q  <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  core_hold_q <= 1'b1;
                  done_q      <= 1'b0;
                  err_q       <= 1'b0;
                  if (len_words == 8'd0) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     core_hold_q <= 1'b0;
                  end else if (len_words > 8'(DEPTH)) begin
                     state_q     <= DONE;
                     err_q       <= 1'b1;
                     core_hold_q <= 1'b0;
                  end else begin
                     state_q      <= RECV;
                     len_q        <= len_words;
                     word_cnt_q   <= 8'd0;
                     byte_cnt_q   <= 2'd0;
                     byte_ready_q <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (accept) begin
                  asm_q      <= asm_d;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) begin
                     state_q      <= WRITE;
                     byte_ready_q <= 1'b0;
                     wr_en_q      <= 1'b1;
                     wr_addr_q    <= {22'd0, word_cnt_q, 2'b00};
                     wr_data_q    <= asm_d;
                  end
               end
            end
            WRITE: begin
               wr_en_q <= 1'b0;
               if (last_word) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  core_hold_q <= 1'b0;
               end else begin
                  state_q      <= RECV;
                  word_cnt_q   <= word_cnt_q + 8'd1;
                  byte_cnt_q   <= 2'd0;
                  byte_ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign core_hold      = core_hold_q;
   assign done           = done_q;
   assign err            = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
// Expected writes are queued as stimulus is driven and popped as wr_en pulses appear.
module tb_instr_mem_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] len_words = 8'd0;
   logic       core_hold;
   logic       done;
   logic       err;

   int errors = 0;
   int checks = 0;
   int writes_seen = 0;
   logic [63:0] exp_q[$];

   instr_mem_loader_if bus ();

   instr_mem_loader #(.DEPTH(128)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .len_words (len_words),
      .bus       (bus.master),
      .core_hold (core_hold),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // All time advances through here; every wr_en pulse is matched against the scoreboard.
   task automatic tick();
      logic [63:0] e;
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
         writes_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h required=none", bus.wr_addr, bus.wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({bus.wr_addr, bus.wr_data} !== e) begin
               errors++;
               $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                        bus.wr_addr, bus.wr_data, e[63:32], e[31:0]);
            end
         end
      end
   endtask

   task automatic pulse_start(input logic [7:0] len);
      start     = 1'b1;
      len_words = len;
      tick();
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      logic rdy;
      int n;
      if (gaps) begin
         bus.byte_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      n = 0;
      forever begin
         rdy = bus.byte_ready;
         tick();
         if (rdy === 1'b1) break;
         n++;
         if (n > 40) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout byte=%h got=not_accepted required=accepted", b);
            break;
         end
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!(done === 1'b1 || err === 1'b1) && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (!(done === 1'b1)) begin
         errors++;
         $display("FAIL done_timeout got done=%b err=%b required done=1", done, err);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, core_hold, done, err} !==
          {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b required 0 0 0 0 1 0 0",
                  bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, core_hold, done, err);
      end
      reset = 1'b0;
      repeat (2) tick();
      checks++;
      if ({bus.byte_ready, core_hold, done} !== 3'b010) begin
         errors++;
         $display("FAIL idle_after_reset got rdy=%b hold=%b done=%b required 0 1 0",
                  bus.byte_ready, core_hold, done);
      end
   endtask

   task automatic test_single_word();
      exp_q.push_back({32'h0, 32'h0000_0013});
      pulse_start(8'd1);
      send_byte(8'h13, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      bus.byte_valid = 1'b0;
      checks++;
      if ({bus.wr_en, bus.byte_ready} !== 2'b10) begin
         errors++;
         $display("FAIL write_cycle got wen=%b rdy=%b required wen=1 rdy=0", bus.wr_en, bus.byte_ready);
      end
      tick();
      checks++;
      if ({done, core_hold, bus.wr_en} !== 3'b100) begin
         errors++;
         $display("FAIL single_done got done=%b hold=%b wen=%b required 1 0 0", done, core_hold, bus.wr_en);
      end
   endtask

   task automatic test_gapped_stream();
      int w0;
      w0 = writes_seen;
      exp_q.push_back({32'h0, 32'h0403_0201});
      exp_q.push_back({32'h4, 32'h0807_0605});
      exp_q.push_back({32'h8, 32'h0C0B_0A09});
      pulse_start(8'd3);
      for (int i = 1; i <= 12; i++) send_byte(8'(i), 1'b1);
      bus.byte_valid = 1'b0;
      wait_done();
      checks++;
      if (writes_seen - w0 !== 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL gapped_write_count got=%0d pending=%0d required=3 pending=0",
                  writes_seen - w0, exp_q.size());
      end
   endtask

   task automatic test_len_too_big();
      int w0;
      w0 = writes_seen;
      pulse_start(8'd129);
      checks++;
      if ({err, done, core_hold} !== 3'b100) begin
         errors++;
         $display("FAIL too_big_flags got err=%b done=%b hold=%b required 1 0 0", err, done, core_hold);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL too_big_ready cycle=%0d got=%b required=0", i, bus.byte_ready);
         end
         tick();
      end
      checks++;
      if (writes_seen != w0 || err !== 1'b1) begin
         errors++;
         $display("FAIL too_big_hold got writes=%0d err=%b required writes=0 err=1", writes_seen - w0, err);
      end
   endtask

   task automatic test_len_zero();
      int w0;
      w0 = writes_seen;
      pulse_start(8'd0);
      checks++;
      if ({done, err, core_hold} !== 3'b100) begin
         errors++;
         $display("FAIL zero_flags got done=%b err=%b hold=%b required 1 0 0", done, err, core_hold);
      end
      repeat (3) tick();
      checks++;
      if (writes_seen != w0) begin
         errors++;
         $display("FAIL zero_writes got=%0d required=0", writes_seen - w0);
      end
   endtask

   task automatic test_start_mid_load();
      int w0;
      logic [7:0] b[8];
      w0 = writes_seen;
      for (int i = 0; i < 8; i++) b[i] = 8'($urandom_range(0, 255));
      exp_q.push_back({32'h0, b[3], b[2], b[1], b[0]});
      exp_q.push_back({32'h4, b[7], b[6], b[5], b[4]});
      pulse_start(8'd2);
      for (int i = 0; i < 5; i++) send_byte(b[i], 1'b0);
      bus.byte_valid = 1'b0;
      pulse_start(8'd1);
      for (int i = 5; i < 8; i++) send_byte(b[i], 1'b0);
      bus.byte_valid = 1'b0;
      wait_done();
      checks++;
      if (writes_seen - w0 !== 2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_start_writes got=%0d pending=%0d required=2 pending=0",
                  writes_seen - w0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_load();
      int w0;
      w0 = writes_seen;
      pulse_start(8'd2);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      bus.byte_in    = 8'hDD;
      bus.byte_valid = 1'b1;
      reset          = 1'b1;
      tick();
      reset          = 1'b0;
      bus.byte_valid = 1'b0;
      checks++;
      if ({bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, core_hold, done, err} !==
          {1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset_outputs got rdy=%b wen=%b addr=%h data=%h hold=%b done=%b err=%b required 0 0 0 0 1 0 0",
                  bus.byte_ready, bus.wr_en, bus.wr_addr, bus.wr_data, core_hold, done, err);
      end
      repeat (6) tick();
      checks++;
      if (writes_seen != w0 || core_hold !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_quiet got writes=%0d hold=%b required writes=0 hold=1", writes_seen - w0, core_hold);
      end
      exp_q.push_back({32'h0, 32'h1122_3344});
      pulse_start(8'd1);
      send_byte(8'h44, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h11, 1'b0);
      bus.byte_valid = 1'b0;
      wait_done();
      checks++;
      if (writes_seen - w0 !== 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL reload_writes got=%0d pending=%0d required=1 pending=0", writes_seen - w0, exp_q.size());
      end
   endtask

   initial begin
      bus.byte_in    = 8'd0;
      bus.byte_valid = 1'b0;
      test_reset();
      test_single_word();
      test_gapped_stream();
      test_len_too_big();
      test_len_zero();
      test_start_mid_load();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
